compressor_ctrl: RTL and testbench
==================================

// Module: compressor_ctrl
// PURPOSE
// - Downstream of the fridge settings stage. Consumes the stored setpoints fgt/frt (5-bit temperature codes)
//   and the measured compartment temperatures. Drives the compressor, the fridge air damper and the defrost heater.
// - Thermostat FSM with per-zone hysteresis, compressor min-on/min-off protection, periodic defrost and a freezer warm alarm.
// - All timing counts pulses of tick (1 Hz strobe, one clk wide).
// PARAMETERS
// HYST        2   demand sets at meas >= setpoint+HYST; clears at meas <= setpoint
// MIN_ON      3   minimum compressor run, ticks
// MIN_OFF     4   minimum compressor rest, ticks; also enforced at power-up
// DEF_INTV    32  accumulated compressor-run ticks that trigger a defrost
// DEF_LEN     8   defrost heater duration, ticks
// ALARM_DELTA 6   freezer warm threshold above frt
// ALARM_TICKS 10  consecutive ticks over threshold before alarm asserts
// PORTS
// clk        in   1  clock, rising edge
// rst_n      in   1  synchronous reset, active low
// i          in   1  appliance power; same net as the fridge stage's power input
// tick       in   1  1 Hz enable strobe
// fgt        in   5  fridge setpoint code (unsigned, larger = warmer)
// frt        in   5  freezer setpoint code
// fg_meas    in   5  measured fridge temperature code
// fr_meas    in   5  measured freezer temperature code
// comp_on    out  1  compressor run
// damper     out  1  fridge damper open
// defrost    out  1  defrost heater on
// alarm      out  1  freezer warm alarm
// state      out  3  current FSM state, for debug and verification
// BEHAVIOUR
// - One clock. Reset is synchronous and active-low.
// - rst_n=0 at a clk edge: state=OFF; all outputs 0; timers, run_acc, alarm count and demand latches all 0.
// - All outputs are registered and decoded from the registered state:
//   comp_on=(COOL); defrost=(DEFROST); damper=COOL & fg_dem; state = encoding.
// - Demand latches (fg_dem, fr_dem) are updated every clk while i=1.
//   Compare in 6 bits: {1'b0,set}+HYST, so no wrap at set=31.
//   Set condition wins if set and clear are both true.
// - States: OFF=0, LOCKOUT=1, IDLE=2, COOL=3, DEFROST=4.
// - Any state, i=0: next state is OFF. Timers, run_acc, demands and alarm are cleared, as at reset.
// - OFF, i=1: go to LOCKOUT; timer<=MIN_OFF.
// - LOCKOUT: on tick, timer decrements. timer==0 -> IDLE; the check is made on the clock after the decrement.
// - IDLE, checked in priority order:
//   - run_acc>=DEF_INTV -> DEFROST; timer<=DEF_LEN.
//   - else fg_dem|fr_dem -> COOL; timer<=MIN_ON.
// - COOL:
//   - On tick: timer decrements (stops at 0); run_acc increments (saturates at 63).
//   - timer==0 and run_acc>=DEF_INTV -> DEFROST. This takes priority over demand.
//   - timer==0 and no demand -> LOCKOUT; timer<=MIN_OFF.
//   - Demand dropping while timer>0 keeps COOL (min-on protection).
// - DEFROST: on tick, timer decrements. At 0 -> LOCKOUT; timer<=MIN_OFF; run_acc<=0.
// - tick on the same edge as a state entry: the freshly loaded timer value wins; that tick is not counted.
// - Alarm:
//   - cnt increments on tick while fr_meas > frt+ALARM_DELTA (6-bit compare).
//   - alarm=1 when cnt reaches ALARM_TICKS. cnt and alarm clear on the first clk where the condition is false.
//   - Alarm is independent of FSM state except OFF.
// STRUCTURE
// - Shared package fridge_pkg: state encodings (ST_OFF..ST_DEFROST), temp-code width TW=5, default parameter values.
//   The fridge settings stage uses the same TW.
// - One sub-module, tick_timer: 4-bit down counter with load, tick, zero flag and saturate-at-0.
//   Instantiated once for the FSM timer. The alarm counter is inline.
// TESTING
// - Reset then i=1, fgt=10, fg_meas=12, frt=4, fr_meas=4:
//   state walks OFF->LOCKOUT->IDLE after 4 ticks; comp_on=1 and damper=1 one clk after IDLE.
// - In COOL, drop fg_meas to 10 after 1 tick: comp_on held until 3 ticks total, then LOCKOUT for 4 ticks; fg_meas=11 does not restart.
// - fgt=31, fg_meas=31: no demand, since 33 exceeds 31 and there is no wrap. fgt=29, fg_meas=31: demand sets.
// - Hold demand for 32 run ticks: DEFROST entered, defrost=1 for 8 ticks, then LOCKOUT, run_acc=0.
// - frt=4, fr_meas=11 for 10 ticks: alarm=1 on the 10th tick. fr_meas=10: alarm=0 next clk.
// - i=0 mid-COOL, then i=1: comp_on=0 next clk, state=OFF; restart enforces the full 4-tick LOCKOUT.
//   Repeat with rst_n=0 mid-DEFROST: defrost=0 and state=OFF next clk.

Source files
------------

// File: rtl/fridge_pkg.sv
// rtl/fridge_pkg.sv - shared fridge types: temp-code width, state encodings, default timings.
package fridge_pkg;

   localparam int TW = 5;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_LOCKOUT = 3'd1,
      ST_IDLE    = 3'd2,
      ST_COOL    = 3'd3,
      ST_DEFROST = 3'd4
   } state_e;

   localparam int HYST_DEF        = 2;
   localparam int MIN_ON_DEF      = 3;
   localparam int MIN_OFF_DEF     = 4;
   localparam int DEF_INTV_DEF    = 32;
   localparam int DEF_LEN_DEF     = 8;
   localparam int ALARM_DELTA_DEF = 6;
   localparam int ALARM_TICKS_DEF = 10;

   // One extra bit so setpoint+offset cannot wrap at the top code.
   function automatic logic [TW:0] widen(input logic [TW-1:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - down counter with clear, load and tick, saturating at zero.
module tick_timer #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         tick_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // A load on the same edge as a tick wins; that tick is dropped.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/compressor_ctrl.sv
// rtl/compressor_ctrl.sv - thermostat FSM driving compressor, damper and defrost heater,
// with min-on/min-off protection, periodic defrost and freezer warm alarm.
module compressor_ctrl
   import fridge_pkg::*;
#(
   parameter int HYST        = HYST_DEF,
   parameter int MIN_ON      = MIN_ON_DEF,
   parameter int MIN_OFF     = MIN_OFF_DEF,
   parameter int DEF_INTV    = DEF_INTV_DEF,
   parameter int DEF_LEN     = DEF_LEN_DEF,
   parameter int ALARM_DELTA = ALARM_DELTA_DEF,
   parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i,
   input  logic          tick,
   input  logic [TW-1:0] fgt,
   input  logic [TW-1:0] frt,
   input  logic [TW-1:0] fg_meas,
   input  logic [TW-1:0] fr_meas,
   output logic          comp_on,
   output logic          damper,
   output logic          defrost,
   output logic          alarm,
   output logic [2:0]    state
);

   localparam logic [5:0] RUN_MAX = 6'd63;

   state_e     state_q, state_d;
   logic       fg_dem_q, fg_dem_d;
   logic       fr_dem_q, fr_dem_d;
   logic [5:0] run_acc_q, run_acc_d;
   logic [3:0] acnt_q, acnt_d;
   logic       alarm_q, alarm_d;

   logic       t_load;
   logic [3:0] t_val;
   logic       t_zero;
   logic       fg_hi, fg_lo, fr_hi, fr_lo, fr_over;
   logic       demand;
   logic       defrost_due;

   assign fg_hi   = widen(fg_meas) >= (widen(fgt) + 6'(HYST));
   assign fg_lo   = fg_meas <= fgt;
   assign fr_hi   = widen(fr_meas) >= (widen(frt) + 6'(HYST));
   assign fr_lo   = fr_meas <= frt;
   assign fr_over = widen(fr_meas) > (widen(frt) + 6'(ALARM_DELTA));

   assign demand      = fg_dem_q | fr_dem_q;
   assign defrost_due = run_acc_q >= 6'(DEF_INTV);

   tick_timer #(.W(4)) u_timer (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (!i),
      .load_i     (t_load),
      .load_val_i (t_val),
      .tick_i     (tick),
      .zero_o     (t_zero)
   );

   // Demand latches: set beats clear when both hold.
   always_comb begin
      fg_dem_d = fg_dem_q;
      fr_dem_d = fr_dem_q;
      if (!i) begin
         fg_dem_d = 1'b0;
         fr_dem_d = 1'b0;
      end else begin
         if (fg_hi)      fg_dem_d = 1'b1;
         else if (fg_lo) fg_dem_d = 1'b0;
         if (fr_hi)      fr_dem_d = 1'b1;
         else if (fr_lo) fr_dem_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_acc_d = run_acc_q;
      t_load    = 1'b0;
      t_val     = 4'd0;
      if (!i) begin
         state_d   = ST_OFF;
         run_acc_d = 6'd0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_LOCKOUT;
               t_load  = 1'b1;
               t_val   = 4'(MIN_OFF);
            end
            ST_LOCKOUT: begin
               if (t_zero) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               if (defrost_due) begin
                  state_d = ST_DEFROST;
                  t_load  = 1'b1;
                  t_val   = 4'(DEF_LEN);
               end else if (demand) begin
                  state_d = ST_COOL;
                  t_load  = 1'b1;
                  t_val   = 4'(MIN_ON);
               end
            end
            ST_COOL: begin
               if (tick && (run_acc_q != RUN_MAX)) run_acc_d = run_acc_q + 6'd1;
               if (t_zero) begin
                  if (defrost_due) begin
                     state_d = ST_DEFROST;
                     t_load  = 1'b1;
                     t_val   = 4'(DEF_LEN);
                  end else if (!demand) begin
                     state_d = ST_LOCKOUT;
                     t_load  = 1'b1;
                     t_val   = 4'(MIN_OFF);
                  end
               end
            end
            ST_DEFROST: begin
               if (t_zero) begin
                  state_d   = ST_LOCKOUT;
                  t_load    = 1'b1;
                  t_val     = 4'(MIN_OFF);
                  run_acc_d = 6'd0;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // Alarm counter is held clear while powered off and restarts whenever the freezer recovers.
   always_comb begin
      acnt_d = acnt_q;
      if (!i || (state_q == ST_OFF) || !fr_over) begin
         acnt_d = 4'd0;
      end else if (tick && (acnt_q != 4'(ALARM_TICKS))) begin
         acnt_d = acnt_q + 4'd1;
      end
      alarm_d = (acnt_d == 4'(ALARM_TICKS));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_OFF;
         fg_dem_q  <= 1'b0;
         fr_dem_q  <= 1'b0;
         run_acc_q <= 6'd0;
         acnt_q    <= 4'd0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fg_dem_q  <= fg_dem_d;
         fr_dem_q  <= fr_dem_d;
         run_acc_q <= run_acc_d;
         acnt_q    <= acnt_d;
         alarm_q   <= alarm_d;
      end
   end

   assign comp_on = (state_q == ST_COOL);
   assign defrost = (state_q == ST_DEFROST);
   assign damper  = (state_q == ST_COOL) && fg_dem_q;
   assign alarm   = alarm_q;
   assign state   = state_q;

endmodule

// File: tb/tb_compressor_ctrl.sv
// tb/tb_compressor_ctrl.sv - directed-vector bench for compressor_ctrl.
module tb_compressor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, i, tick;
   logic [4:0] fgt, frt, fg_meas, fr_meas;
   logic       comp_on, damper, defrost, alarm;
   logic [2:0] state;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [7:0] OFF = 8'd0, LOCK = 8'd1, IDLE = 8'd2, COOL = 8'd3, DEFR = 8'd4;

   compressor_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i       (i),
      .tick    (tick),
      .fgt     (fgt),
      .frt     (frt),
      .fg_meas (fg_meas),
      .fr_meas (fr_meas),
      .comp_on (comp_on),
      .damper  (damper),
      .defrost (defrost),
      .alarm   (alarm),
      .state   (state)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Each tick is one clk wide and followed by one quiet clk.
   task automatic tick_n(input int n);
      repeat (n) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic restart_to_cool();
      rst_n = 1'b0;
      clk_n(1);
      rst_n = 1'b1;
      clk_n(1);
      tick_n(4);
      clk_n(1);
   endtask

   initial begin
      rst_n = 1'b0; i = 1'b0; tick = 1'b0;
      fgt = 5'd10; fg_meas = 5'd12; frt = 5'd4; fr_meas = 5'd4;
      clk_n(2);
      check_vec("rst_state", 8'(state), OFF);
      check_vec("rst_comp", 8'(comp_on), 8'd0);
      check_vec("rst_outs", 8'({damper, defrost, alarm}), 8'd0);

      rst_n = 1'b1; i = 1'b1;
      clk_n(1);
      check_vec("pwr_lockout", 8'(state), LOCK);
      tick_n(3);
      check_vec("lock_3ticks", 8'(state), LOCK);
      tick_n(1);
      check_vec("lock_to_idle", 8'(state), IDLE);
      clk_n(1);
      check_vec("idle_to_cool", 8'(state), COOL);
      check_vec("cool_comp", 8'(comp_on), 8'd1);
      check_vec("cool_damper", 8'(damper), 8'd1);

      tick_n(1);
      fg_meas = 5'd10;
      clk_n(1);
      check_vec("minon_hold", 8'(comp_on), 8'd1);
      check_vec("damper_drop", 8'(damper), 8'd0);
      tick_n(1);
      check_vec("minon_2ticks", 8'(state), COOL);
      tick_n(1);
      check_vec("minon_expire", 8'(state), LOCK);
      check_vec("minon_comp_off", 8'(comp_on), 8'd0);
      fg_meas = 5'd11;
      tick_n(3);
      check_vec("minoff_hold", 8'(state), LOCK);
      tick_n(1);
      check_vec("minoff_idle", 8'(state), IDLE);
      clk_n(2);
      check_vec("hyst_no_restart", 8'(state), IDLE);

      fgt = 5'd31; fg_meas = 5'd31;
      clk_n(3);
      check_vec("no_wrap_31", 8'(state), IDLE);
      fgt = 5'd29;
      clk_n(2);
      check_vec("dem_at_29", 8'(state), COOL);
      check_vec("dem_damper", 8'(damper), 8'd1);

      restart_to_cool();
      check_vec("def_cool", 8'(state), COOL);
      tick_n(31);
      check_vec("def_31runs", 8'(state), COOL);
      tick_n(1);
      check_vec("def_enter", 8'(state), DEFR);
      check_vec("def_heater", 8'(defrost), 8'd1);
      check_vec("def_comp_off", 8'(comp_on), 8'd0);
      tick_n(7);
      check_vec("def_7ticks", 8'(defrost), 8'd1);
      tick_n(1);
      check_vec("def_exit", 8'(state), LOCK);
      tick_n(4);
      clk_n(1);
      check_vec("runacc_cleared", 8'(state), COOL);

      fr_meas = 5'd11;
      tick_n(9);
      check_vec("alarm_9ticks", 8'(alarm), 8'd0);
      tick = 1'b1;
      clk_n(1);
      tick = 1'b0;
      check_vec("alarm_10th", 8'(alarm), 8'd1);
      clk_n(2);
      check_vec("alarm_holds", 8'(alarm), 8'd1);
      fr_meas = 5'd10;
      clk_n(1);
      check_vec("alarm_clear", 8'(alarm), 8'd0);
      fr_meas = 5'd4;

      i = 1'b0;
      clk_n(1);
      check_vec("pwroff_state", 8'(state), OFF);
      check_vec("pwroff_comp", 8'(comp_on), 8'd0);
      i = 1'b1;
      clk_n(1);
      check_vec("pwron_lock", 8'(state), LOCK);
      tick_n(3);
      check_vec("pwron_3ticks", 8'(state), LOCK);
      tick_n(1);
      check_vec("pwron_idle", 8'(state), IDLE);
      clk_n(1);
      check_vec("pwron_cool", 8'(state), COOL);

      tick_n(32);
      check_vec("def2_enter", 8'(state), DEFR);
      tick_n(2);
      rst_n = 1'b0;
      clk_n(1);
      check_vec("rst_mid_def_state", 8'(state), OFF);
      check_vec("rst_mid_def_heater", 8'(defrost), 8'd0);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
